// File: rtl/spi_master_pkg.sv
// Shared types and defaults for the multi-chip-select SPI master.
package spi_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD
    } state_t;

    localparam int DEF_N_CS     = 3;
    localparam int DEF_MAX_BITS = 16;
    localparam int DEF_DIV_W    = 8;

    // A zero or oversize length means "full width".
    function automatic int clamp_len(input int len, input int max_bits);
        return ((len == 0) || (len > max_bits)) ? max_bits : len;
    endfunction

endpackage

// File: rtl/spi_master_mcs_if.sv
// Request/response bus between the board controller and the SPI master.
interface spi_master_mcs_if
    import spi_master_pkg::*;
#(
    parameter int N_CS     = DEF_N_CS,
    parameter int MAX_BITS = DEF_MAX_BITS,
    parameter int DIV_W    = DEF_DIV_W
) ();

    localparam int SEL_W = (N_CS > 1) ? $clog2(N_CS) : 1;
    localparam int LEN_W = $clog2(MAX_BITS + 1);

    // Handshake: start_i is a request that is taken only while busy_o=0; the
    // accept edge raises busy_o, and the transaction ends with a single-cycle
    // done_o (busy_o already low) carrying rx_data_o. A bad cs_sel_i is
    // answered with a single-cycle err_o instead. There is no queueing.
    logic                start_i;
    logic [SEL_W-1:0]    cs_sel_i;
    logic [LEN_W-1:0]    len_i;
    logic                cpol_i;
    logic                cpha_i;
    logic [DIV_W-1:0]    div_i;
    logic [MAX_BITS-1:0] tx_data_i;
    logic                busy_o;
    logic                done_o;
    logic                err_o;
    logic [MAX_BITS-1:0] rx_data_o;
    state_t              state_o;

    modport master (
        output start_i, cs_sel_i, len_i, cpol_i, cpha_i, div_i, tx_data_i,
        input  busy_o, done_o, err_o, rx_data_o, state_o
    );

    modport slave (
        input  start_i, cs_sel_i, len_i, cpol_i, cpha_i, div_i, tx_data_i,
        output busy_o, done_o, err_o, rx_data_o, state_o
    );

endinterface

// File: rtl/spi_clk_gen.sv
// Half-period timer: strobes every div+1 cycles and numbers SCLK edges from 1.
module spi_clk_gen #(
    parameter int DIV_W  = 8,
    parameter int EDGE_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              edge_en_i,
    input  logic [DIV_W-1:0]  div_i,
    output logic              tick_o,
    output logic              edge_o,
    output logic [EDGE_W-1:0] edge_idx_o
);

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;

    always_comb begin
        tick_o     = en_i && (cnt_q == div_i);
        edge_o     = tick_o && edge_en_i;
        edge_idx_o = edge_cnt_q + EDGE_W'(1);
        cnt_d      = '0;
        edge_cnt_d = '0;
        if (en_i) begin
            cnt_d      = tick_o ? '0 : cnt_q + DIV_W'(1);
            edge_cnt_d = edge_o ? edge_idx_o : edge_cnt_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            edge_cnt_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_mcs.sv
// SPI master: N chip selects, 1..MAX_BITS word length, all CPOL/CPHA modes,
// programmable SCLK half-period of div+1 clocks.
module spi_master_mcs
    import spi_master_pkg::*;
#(
    parameter int N_CS     = DEF_N_CS,
    parameter int MAX_BITS = DEF_MAX_BITS,
    parameter int DIV_W    = DEF_DIV_W
) (
    input  logic            clk_i,
    input  logic            rst_i,
    spi_master_mcs_if.slave ctrl,
    output logic            sclk_o,
    output logic            mosi_o,
    input  logic            miso_i,
    output logic [N_CS-1:0] cs_n_o
);

    localparam int SEL_W  = (N_CS > 1) ? $clog2(N_CS) : 1;
    localparam int LEN_W  = $clog2(MAX_BITS + 1);
    localparam int EDGE_W = LEN_W + 1;
    localparam logic [SEL_W:0] N_CS_LIM = (SEL_W + 1)'(N_CS);

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [N_CS-1:0]     cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [MAX_BITS-1:0] tx_q, tx_d;
    logic [MAX_BITS-1:0] rx_sh_q, rx_sh_d;
    logic [MAX_BITS-1:0] rx_data_q, rx_data_d;

    logic                tick;
    logic                edge_stb;
    logic [EDGE_W-1:0]   edge_idx;
    logic                sel_ok;
    logic                sample;
    logic                last_edge;
    logic [LEN_W-1:0]    len_c;
    logic [MAX_BITS-1:0] tx_aligned;

    spi_clk_gen #(
        .DIV_W  (DIV_W),
        .EDGE_W (EDGE_W)
    ) u_clk_gen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (state_q != ST_IDLE),
        .edge_en_i  (state_q == ST_SHIFT),
        .div_i      (div_q),
        .tick_o     (tick),
        .edge_o     (edge_stb),
        .edge_idx_o (edge_idx)
    );

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        len_d     = len_q;
        div_d     = div_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        sel_ok    = ({1'b0, ctrl.cs_sel_i} < N_CS_LIM);
        len_c     = LEN_W'(clamp_len(int'(ctrl.len_i), MAX_BITS));
        // Left-align so the first bit to send is always the register MSB.
        tx_aligned = ctrl.tx_data_i << (MAX_BITS - int'(len_c));
        // Odd edges are leading; CPHA=0 samples on leading, CPHA=1 on trailing.
        sample    = edge_idx[0] ^ cpha_q;
        last_edge = (edge_idx == {len_q, 1'b0});

        unique case (state_q)
            ST_IDLE: begin
                if (ctrl.start_i) begin
                    if (sel_ok) begin
                        state_d = ST_SETUP;
                        busy_d  = 1'b1;
                        cpol_d  = ctrl.cpol_i;
                        cpha_d  = ctrl.cpha_i;
                        len_d   = len_c;
                        div_d   = ctrl.div_i;
                        sclk_d  = ctrl.cpol_i;
                        rx_sh_d = '0;
                        for (int i = 0; i < N_CS; i++) begin
                            cs_n_d[i] = (i != int'(ctrl.cs_sel_i));
                        end
                        if (!ctrl.cpha_i) begin
                            mosi_d = tx_aligned[MAX_BITS-1];
                            tx_d   = tx_aligned << 1;
                        end else begin
                            mosi_d = 1'b0;
                            tx_d   = tx_aligned;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (tick) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (edge_stb) begin
                    sclk_d = ~sclk_q;
                    if (sample) begin
                        rx_sh_d = {rx_sh_q[MAX_BITS-2:0], miso_i};
                    end else if (!last_edge) begin
                        mosi_d = tx_q[MAX_BITS-1];
                        tx_d   = tx_q << 1;
                    end
                    if (last_edge) state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    cs_n_d    = '1;
                    mosi_d    = 1'b0;
                    rx_data_d = rx_sh_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cs_n_q    <= '1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            len_q     <= '0;
            div_q     <= '0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            len_q     <= len_d;
            div_q     <= div_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign ctrl.busy_o    = busy_q;
    assign ctrl.done_o    = done_q;
    assign ctrl.err_o     = err_q;
    assign ctrl.rx_data_o = rx_data_q;
    assign ctrl.state_o   = state_q;
    assign sclk_o         = sclk_q;
    assign mosi_o         = mosi_q;
    assign cs_n_o         = cs_n_q;

endmodule

// File: tb/tb_spi_master_mcs.sv
// Directed bench for spi_master_mcs: modes 0/1/3, rejection, back-to-back,
// mid-transaction reset and zero-length clamping.
module tb_spi_master_mcs;
    import spi_master_pkg::*;

    logic       clk;
    logic       rst;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic [2:0] cs_n;

    int tests = 0;
    int fails = 0;

    logic        loop_en = 1'b1;
    logic        slave_miso = 1'b0;
    logic [15:0] slave_word = 16'h0000;
    int          slave_idx = 15;
    logic        slave_prev_sclk = 1'b0;

    spi_master_mcs_if #(.N_CS(3), .MAX_BITS(16), .DIV_W(8)) ctrl ();

    spi_master_mcs #(.N_CS(3), .MAX_BITS(16), .DIV_W(8)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .ctrl   (ctrl.slave),
        .sclk_o (sclk),
        .mosi_o (mosi),
        .miso_i (miso),
        .cs_n_o (cs_n)
    );

    assign miso = loop_en ? mosi : slave_miso;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave for target 0: shifts out slave_word MSB first on every falling SCLK.
    always @(negedge clk) begin
        if (cs_n[0] !== 1'b0) begin
            slave_idx = 15;
        end else if (slave_prev_sclk === 1'b1 && sclk === 1'b0 && slave_idx >= 0) begin
            slave_miso = slave_word[slave_idx];
            slave_idx  = slave_idx - 1;
        end
        slave_prev_sclk = sclk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [1:0] sel, input logic [4:0] len, input logic cpol,
                          input logic cpha, input logic [7:0] div, input logic [15:0] tx,
                          input bit hold);
        @(negedge clk);
        ctrl.cs_sel_i  = sel;
        ctrl.len_i     = len;
        ctrl.cpol_i    = cpol;
        ctrl.cpha_i    = cpha;
        ctrl.div_i     = div;
        ctrl.tx_data_i = tx;
        ctrl.start_i   = 1'b1;
        @(negedge clk);
        if (!hold) ctrl.start_i = 1'b0;
    endtask

    // Watches from the first negedge after accept until done_o.
    task automatic track(input int limit, output int cycles, output int cs_cycles,
                         output int rises, output int falls, output int first_edge,
                         output logic [31:0] mseq);
        logic prev;
        prev       = sclk;
        cycles     = 0;
        cs_cycles  = (cs_n !== 3'b111) ? 1 : 0;
        rises      = 0;
        falls      = 0;
        first_edge = -1;
        mseq       = '0;
        while (ctrl.done_o !== 1'b1 && cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (sclk !== prev) begin
                if (first_edge < 0) first_edge = cycles;
                if (sclk === 1'b1) begin
                    rises++;
                    mseq = {mseq[30:0], mosi};
                end else begin
                    falls++;
                end
            end
            prev = sclk;
            if (cs_n !== 3'b111) cs_cycles++;
        end
        check("done_seen", {31'b0, ctrl.done_o}, 32'd1);
    endtask

    int          cyc, csc, ri, fa, fe, edges;
    logic [31:0] ms;
    logic        prev_s;

    initial begin
        rst            = 1'b1;
        ctrl.start_i   = 1'b0;
        ctrl.cs_sel_i  = '0;
        ctrl.len_i     = '0;
        ctrl.cpol_i    = 1'b0;
        ctrl.cpha_i    = 1'b0;
        ctrl.div_i     = '0;
        ctrl.tx_data_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_cs_n", {29'b0, cs_n}, 32'h7);
        check("rst_sclk", {31'b0, sclk}, 32'd0);
        check("rst_mosi", {31'b0, mosi}, 32'd0);
        check("rst_busy", {31'b0, ctrl.busy_o}, 32'd0);
        check("rst_done", {31'b0, ctrl.done_o}, 32'd0);
        check("rst_err", {31'b0, ctrl.err_o}, 32'd0);
        check("rst_rx", {16'b0, ctrl.rx_data_o}, 32'd0);
        check("rst_state", {30'b0, ctrl.state_o}, {30'b0, ST_IDLE});

        // Mode 0, div 0, len 8, loopback
        loop_en = 1'b1;
        launch(2'd0, 5'd8, 1'b0, 1'b0, 8'd0, 16'h00A5, 1'b0);
        check("m0_busy_acc", {31'b0, ctrl.busy_o}, 32'd1);
        check("m0_cs_acc", {29'b0, cs_n}, 32'h6);
        check("m0_mosi_first", {31'b0, mosi}, 32'd1);
        track(100, cyc, csc, ri, fa, fe, ms);
        check("m0_cycles", cyc, 32'd18);
        check("m0_cs_cycles", csc, 32'd18);
        check("m0_rises", ri, 32'd8);
        check("m0_falls", fa, 32'd8);
        check("m0_first_edge", fe, 32'd2);
        check("m0_mosi_seq", ms, 32'hA5);
        check("m0_rx", {16'b0, ctrl.rx_data_o}, 32'h00A5);
        check("m0_busy_done", {31'b0, ctrl.busy_o}, 32'd0);
        check("m0_cs_done", {29'b0, cs_n}, 32'h7);
        @(negedge clk);
        check("m0_done_once", {31'b0, ctrl.done_o}, 32'd0);
        check("m0_mosi_idle", {31'b0, mosi}, 32'd0);

        // Mode 3, div 3, len 16, slave returns 0xBEEF
        loop_en    = 1'b0;
        slave_word = 16'hBEEF;
        launch(2'd0, 5'd16, 1'b1, 1'b1, 8'd3, 16'h1234, 1'b0);
        check("m3_sclk_idle", {31'b0, sclk}, 32'd1);
        check("m3_cs_acc", {29'b0, cs_n}, 32'h6);
        track(400, cyc, csc, ri, fa, fe, ms);
        check("m3_cycles", cyc, 32'd136);
        check("m3_first_edge", fe, 32'd8);
        check("m3_rises", ri, 32'd16);
        check("m3_falls", fa, 32'd16);
        check("m3_mosi_seq", ms, 32'h1234);
        check("m3_rx", {16'b0, ctrl.rx_data_o}, 32'hBEEF);
        check("m3_sclk_end", {31'b0, sclk}, 32'd1);

        // Rejected select
        launch(2'd3, 5'd8, 1'b0, 1'b0, 8'd0, 16'h00FF, 1'b0);
        check("rej_err", {31'b0, ctrl.err_o}, 32'd1);
        check("rej_cs", {29'b0, cs_n}, 32'h7);
        check("rej_busy", {31'b0, ctrl.busy_o}, 32'd0);
        check("rej_state", {30'b0, ctrl.state_o}, {30'b0, ST_IDLE});
        @(negedge clk);
        check("rej_err_once", {31'b0, ctrl.err_o}, 32'd0);
        check("rej_busy2", {31'b0, ctrl.busy_o}, 32'd0);

        // start held high: back-to-back, len 4, div 1
        loop_en = 1'b1;
        launch(2'd1, 5'd4, 1'b0, 1'b0, 8'd1, 16'h0009, 1'b1);
        track(100, cyc, csc, ri, fa, fe, ms);
        check("b2b_cycles1", cyc, 32'd20);
        check("b2b_rx1", {16'b0, ctrl.rx_data_o}, 32'h0009);
        check("b2b_mosi1", ms, 32'h9);
        check("b2b_busy_done", {31'b0, ctrl.busy_o}, 32'd0);
        @(negedge clk);
        check("b2b_reaccept", {31'b0, ctrl.busy_o}, 32'd1);
        check("b2b_cs", {29'b0, cs_n}, 32'h5);
        check("b2b_single_done", {31'b0, ctrl.done_o}, 32'd0);
        track(100, cyc, csc, ri, fa, fe, ms);
        ctrl.start_i = 1'b0;
        check("b2b_cycles2", cyc, 32'd20);
        check("b2b_rx2", {16'b0, ctrl.rx_data_o}, 32'h0009);
        @(negedge clk);
        check("b2b_done_end", {31'b0, ctrl.done_o}, 32'd0);
        check("b2b_idle", {31'b0, ctrl.busy_o}, 32'd0);
        check("b2b_cs_end", {29'b0, cs_n}, 32'h7);

        // Reset on the 5th SCLK edge
        launch(2'd2, 5'd8, 1'b0, 1'b0, 8'd1, 16'h00FF, 1'b0);
        prev_s = sclk;
        edges  = 0;
        cyc    = 0;
        while (edges < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (sclk !== prev_s) edges++;
            prev_s = sclk;
        end
        check("rst5_edges", edges, 32'd5);
        rst = 1'b1;
        @(negedge clk);
        check("rst5_cs", {29'b0, cs_n}, 32'h7);
        check("rst5_sclk", {31'b0, sclk}, 32'd0);
        check("rst5_busy", {31'b0, ctrl.busy_o}, 32'd0);
        check("rst5_done", {31'b0, ctrl.done_o}, 32'd0);
        check("rst5_mosi", {31'b0, mosi}, 32'd0);
        rst = 1'b0;
        edges = 0;
        repeat (30) begin
            @(negedge clk);
            if (ctrl.done_o === 1'b1) edges++;
        end
        check("rst5_no_done", edges, 32'd0);
        launch(2'd0, 5'd8, 1'b0, 1'b0, 8'd0, 16'h003C, 1'b0);
        track(100, cyc, csc, ri, fa, fe, ms);
        check("rst5_fresh_cycles", cyc, 32'd18);
        check("rst5_fresh_rx", {16'b0, ctrl.rx_data_o}, 32'h003C);

        // len 0 clamps to 16 bits, mode 1
        launch(2'd2, 5'd0, 1'b0, 1'b1, 8'd0, 16'hC3A5, 1'b0);
        check("len0_cs", {29'b0, cs_n}, 32'h3);
        track(200, cyc, csc, ri, fa, fe, ms);
        check("len0_cycles", cyc, 32'd34);
        check("len0_edges", ri + fa, 32'd32);
        check("len0_mosi_seq", ms, 32'hC3A5);
        check("len0_rx", {16'b0, ctrl.rx_data_o}, 32'hC3A5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
